// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: blank pattern,
// active-low hex glyphs ({g,f,e,d,c,b,a}, lit segment = 0) and scan FSM states.
package disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam logic [6:0] GLYPH_OFF = 7'h7F;

    typedef enum logic [0:0] {
        ST_DEAD,
        ST_DRIVE
    } scan_st_e;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Frame-load and display-pin bundle of the scan controller.
// master: frame source / board side, slave: the controller.
interface disp_scan_ctrl_if;

    logic        load;
    logic [31:0] hexs;
    logic [7:0]  points;
    logic [7:0]  les;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;
    logic        upd;

    modport master (
        output load, hexs, points, les,
        input  an, seg, frame_tick, upd
    );

    modport slave (
        input  load, hexs, points, les,
        output an, seg, frame_tick, upd
    );

endinterface

// File: rtl/hex7seg_dec.sv
// Combinational nibble to active-low 7-segment glyph ({g,f,e,d,c,b,a}).
module hex7seg_dec
    import disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Glyph lookup
    always_comb begin
        seg_o = GLYPH_OFF;
        unique case (nib_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = GLYPH_OFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// 8-digit common-anode seven-segment scan controller.
// Each digit slot is DEAD_CYC blank cycles then SCAN_DIV-DEAD_CYC drive cycles.
// Loaded frames wait in a pending register and are committed to the shadow
// (displayed) frame only at the digit 7 -> 0 wrap, so a scan is never torn.
// Optional build macro DISP_LZ_BLANK_EN: suppress leading zero digits.
// Parameters must satisfy SCAN_DIV >= 2, DEAD_CYC >= 1, DEAD_CYC < SCAN_DIV.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DEAD_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    disp_scan_ctrl_if.slave bus
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYC - 1);

    // Scan state
    scan_st_e        st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;

    // Shadow (displayed) frame
    logic [31:0]     sh_hexs_q, sh_hexs_d;
    logic [7:0]      sh_pts_q, sh_pts_d;
    logic [7:0]      sh_les_q, sh_les_d;

    // Pending frame
    logic [31:0]     pd_hexs_q, pd_hexs_d;
    logic [7:0]      pd_pts_q, pd_pts_d;
    logic [7:0]      pd_les_q, pd_les_d;
    logic            pend_vld_q, pend_vld_d;

    // Registered pins
    logic [7:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic            frame_tick_q, frame_tick_d;
    logic            upd_q, upd_d;

    logic            slot_end;
    logic            boundary;
    logic            next_boundary;
    logic [3:0]      cur_nib;
    logic [6:0]      dec_seg;
    logic [7:0]      lz_mask;

    // Slot counter, digit index and FSM next state
    always_comb begin
        slot_end = (cnt_q == CntLast);
        boundary = slot_end && (idx_q == 3'd7);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 3'd1 : idx_q;
        st_d     = st_q;
        unique case (st_q)
            ST_DEAD:  if (cnt_q == DeadLast) st_d = ST_DRIVE;
            ST_DRIVE: if (slot_end) st_d = ST_DEAD;
            default:  st_d = ST_DEAD;
        endcase
    end

    // Frame load / commit: a load on the wrap cycle bypasses pending
    always_comb begin
        sh_hexs_d  = sh_hexs_q;
        sh_pts_d   = sh_pts_q;
        sh_les_d   = sh_les_q;
        pd_hexs_d  = pd_hexs_q;
        pd_pts_d   = pd_pts_q;
        pd_les_d   = pd_les_q;
        pend_vld_d = pend_vld_q;
        if (bus.load && boundary) begin
            sh_hexs_d  = bus.hexs;
            sh_pts_d   = bus.points;
            sh_les_d   = bus.les;
            pend_vld_d = 1'b0;
        end else if (bus.load) begin
            pd_hexs_d  = bus.hexs;
            pd_pts_d   = bus.points;
            pd_les_d   = bus.les;
            pend_vld_d = 1'b1;
        end else if (boundary && pend_vld_q) begin
            sh_hexs_d  = pd_hexs_q;
            sh_pts_d   = pd_pts_q;
            sh_les_d   = pd_les_q;
            pend_vld_d = 1'b0;
        end
    end

    // Leading-zero suppression mask from the shadow frame
`ifdef DISP_LZ_BLANK_EN
    logic lz_run;
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            lz_run     = lz_run && (sh_hexs_q[i*4 +: 4] == 4'h0);
            lz_mask[i] = lz_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign cur_nib = sh_hexs_q[{idx_q, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    // Pin values for the next cycle; frame_tick/upd look one cycle ahead so
    // they are high during the wrap cycle itself
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (st_q == ST_DRIVE) begin
            an_d = ~(8'h01 << idx_q);
            if (!sh_les_q[idx_q]) begin
                seg_d = {~sh_pts_q[idx_q], lz_mask[idx_q] ? GLYPH_OFF : dec_seg};
            end
        end
        next_boundary = (cnt_d == CntLast) && (idx_d == 3'd7);
        frame_tick_d  = next_boundary;
        upd_d         = next_boundary && pend_vld_d;
    end

    // Scan FSM, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= ST_DEAD;
            cnt_q        <= '0;
            idx_q        <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
            upd_q        <= 1'b0;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
            upd_q        <= upd_d;
        end
    end

    // Shadow and pending frame registers; reset leaves the display blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hexs_q  <= '0;
            sh_pts_q   <= '0;
            sh_les_q   <= 8'hFF;
            pd_hexs_q  <= '0;
            pd_pts_q   <= '0;
            pd_les_q   <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            sh_hexs_q  <= sh_hexs_d;
            sh_pts_q   <= sh_pts_d;
            sh_les_q   <= sh_les_d;
            pd_hexs_q  <= pd_hexs_d;
            pd_pts_q   <= pd_pts_d;
            pd_les_q   <= pd_les_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.upd        = upd_q;

endmodule
